// File: rtl/monitor_mem_master.sv
// Monitor-link memory master: byte-serial 'W'/'R' commands drive a 32-bit memory program port.
// Optional macro MONITOR_AUTOINC_EN adds address auto-increment plus the 'w'/'r' short commands.
module monitor_mem_master #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        prg_we,
  output logic [31:0] prg_addr,
  output logic [31:0] prg_wd,
  input  logic [31:0] prg_rd,
  output logic        busy
);
  localparam int unsigned CNT_W = 2;
  localparam int unsigned LAT_W = 2;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
`ifdef MONITOR_AUTOINC_EN
  localparam logic [7:0] CMD_WR_INC = 8'h77;
  localparam logic [7:0] CMD_RD_INC = 8'h72;
`endif

  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, SEND} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [LAT_W-1:0] lat, lat_n;
  logic             is_wr, is_wr_n;
  logic [31:0]      addr, addr_n;
  logic [31:0]      data, data_n;
  logic [31:0]      resp, resp_n;
  logic             tx_valid_n, rx_ready_n, prg_we_n, busy_n;
  logic             rx_fire, tx_fire;

  assign rx_fire  = rx_valid && rx_ready;
  assign tx_fire  = tx_valid && tx_ready;
  assign tx_data  = resp[31:24];
  assign prg_addr = {addr[31:2], 2'b00};
  assign prg_wd   = data;

  // State register and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lat      <= '0;
      is_wr    <= 1'b0;
      addr     <= '0;
      data     <= '0;
      resp     <= '0;
      tx_valid <= 1'b0;
      rx_ready <= 1'b1;
      prg_we   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      lat      <= lat_n;
      is_wr    <= is_wr_n;
      addr     <= addr_n;
      data     <= data_n;
      resp     <= resp_n;
      tx_valid <= tx_valid_n;
      rx_ready <= rx_ready_n;
      prg_we   <= prg_we_n;
      busy     <= busy_n;
    end
  end

  // Next state; cnt counts operand bytes on rx and remaining response bytes in SEND
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lat_n      = lat;
    is_wr_n    = is_wr;
    addr_n     = addr;
    data_n     = data;
    resp_n     = resp;
    tx_valid_n = tx_valid;

    case (state)
      IDLE: begin
        if (rx_fire) begin
          cnt_n = '0;
          lat_n = '0;
          case (rx_data)
            CMD_WR: begin
              is_wr_n = 1'b1;
              state_n = GET_ADDR;
            end
            CMD_RD: begin
              is_wr_n = 1'b0;
              state_n = GET_ADDR;
            end
`ifdef MONITOR_AUTOINC_EN
            CMD_WR_INC: state_n = GET_DATA;
            CMD_RD_INC: state_n = READ_WAIT;
`endif
            default: begin
              resp_n     = {RSP_NAK, 24'h000000};
              tx_valid_n = 1'b1;
              state_n    = SEND;
            end
          endcase
        end
      end

      GET_ADDR: begin
        if (rx_fire) begin
          addr_n = {addr[23:0], rx_data};
          cnt_n  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(3)) begin
            lat_n   = '0;
            state_n = is_wr ? GET_DATA : READ_WAIT;
          end
        end
      end

      GET_DATA: begin
        if (rx_fire) begin
          data_n = {data[23:0], rx_data};
          cnt_n  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(3)) state_n = WRITE;
        end
      end

      WRITE: begin
        resp_n     = {RSP_ACK, 24'h000000};
        cnt_n      = '0;
        tx_valid_n = 1'b1;
        state_n    = SEND;
`ifdef MONITOR_AUTOINC_EN
        addr_n     = addr + 32'd4;
`endif
      end

      READ_WAIT: begin
        if (lat == LAT_W'(RD_LATENCY - 1)) begin
          resp_n     = prg_rd;
          cnt_n      = CNT_W'(3);
          tx_valid_n = 1'b1;
          state_n    = SEND;
`ifdef MONITOR_AUTOINC_EN
          addr_n     = addr + 32'd4;
`endif
        end else begin
          lat_n = lat + LAT_W'(1);
        end
      end

      SEND: begin
        if (tx_fire) begin
          if (cnt == '0) begin
            tx_valid_n = 1'b0;
            state_n    = IDLE;
          end else begin
            resp_n = {resp[23:0], 8'h00};
            cnt_n  = cnt - CNT_W'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase

    rx_ready_n = (state_n == IDLE) || (state_n == GET_ADDR) || (state_n == GET_DATA);
    busy_n     = (state_n != IDLE);
    prg_we_n   = (state_n == WRITE);
  end

endmodule

// File: tb/tb_monitor_mem_master.sv
// Bench for monitor_mem_master: unit 0 has RD_LATENCY=1, unit 1 has RD_LATENCY=3.
// Compile with MONITOR_AUTOINC_EN defined to exercise the auto-increment build.
`timescale 1ns/1ps
module tb_monitor_mem_master;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data  [2];
  logic        rx_valid [2];
  logic        rx_ready [2];
  logic [7:0]  tx_data  [2];
  logic        tx_valid [2];
  logic        tx_ready [2];
  logic        prg_we   [2];
  logic [31:0] prg_addr [2];
  logic [31:0] prg_wd   [2];
  logic [31:0] prg_rd   [2];
  logic        busy     [2];

  int total, bad;

  // Environment memory (written by the DUT) and reference model state
  logic [31:0] env_mem [logic [32:0]];
  logic [31:0] ref_mem [logic [32:0]];
  logic [31:0] ra [2];
  logic [7:0]  exp_tx [$];
  logic [63:0] exp_wr [$];
  logic [7:0]  obs_tx [2][$];
  logic [63:0] obs_wr [2][$];
  int          viol [2];
  logic        hold [2];
  logic [7:0]  hold_d [2];
  logic        we_d [2];
  logic [31:0] ahist [2][2];
  int          rdy_pct [2];
  logic        force_low [2];

  always #5 clk = ~clk;

  monitor_mem_master #(.RD_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .prg_we(prg_we[0]),
    .prg_addr(prg_addr[0]), .prg_wd(prg_wd[0]), .prg_rd(prg_rd[0]), .busy(busy[0]));

  monitor_mem_master #(.RD_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .prg_we(prg_we[1]),
    .prg_addr(prg_addr[1]), .prg_wd(prg_wd[1]), .prg_rd(prg_rd[1]), .busy(busy[1]));

  function automatic logic [31:0] hash_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] env_rd(input int u, input logic [31:0] a);
    logic [32:0] k;
    k = {u[0], a};
    if (env_mem.exists(k)) return env_mem[k];
    return hash_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int u, input logic [31:0] a);
    logic [32:0] k;
    k = {u[0], a};
    if (ref_mem.exists(k)) return ref_mem[k];
    return hash_word(a);
  endfunction

  // Link sink with random or forced-low backpressure
  always @(negedge clk)
    for (int u = 0; u < 2; u++)
      tx_ready[u] = !force_low[u] && (int'($urandom_range(99)) < rdy_pct[u]);

  // Memory with latency L: data visible L-1 cycles after the address, plus link/port monitors
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (prg_we[u]) begin
        env_mem[{u[0], prg_addr[u]}] = prg_wd[u];
        obs_wr[u].push_back({prg_addr[u], prg_wd[u]});
      end
      if (tx_valid[u] && tx_ready[u]) obs_tx[u].push_back(tx_data[u]);
      if (reset) begin
        hold[u] = 1'b0;
        we_d[u] = 1'b0;
      end else begin
        if (hold[u] && !(tx_valid[u] && tx_data[u] == hold_d[u])) viol[u]++;
        if (prg_we[u] && (we_d[u] || !busy[u] || prg_addr[u][1:0] != 2'b00)) viol[u]++;
        hold[u] = tx_valid[u] && !tx_ready[u];
        we_d[u] = prg_we[u];
      end
      hold_d[u]   = tx_data[u];
      ahist[u][1] = ahist[u][0];
      ahist[u][0] = prg_addr[u];
    end
    #1;
    prg_rd[0] = env_rd(0, prg_addr[0]);
    prg_rd[1] = env_rd(1, ahist[1][1]);
  end

  task automatic send_byte(input int u, input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data[u]  = b;
    rx_valid[u] = 1'b1;
    n = 0;
    while (!rx_ready[u] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL rx_timeout u%0d: rx_ready got 0 want 1 for byte %h", u, b);
    end
    @(posedge clk);
    #1 rx_valid[u] = 1'b0;
  endtask

  task automatic clear_q(input int u);
    obs_tx[u].delete();
    obs_wr[u].delete();
    exp_tx.delete();
    exp_wr.delete();
  endtask

  // Send one command and update the reference model from the command rules
  task automatic issue_cmd(input int u, input logic [7:0] cmd, input logic [31:0] a,
                           input logic [31:0] d, input int gap);
    logic [7:0]  bytes [$];
    logic [31:0] ea, rv;
    bytes.push_back(cmd);
    case (cmd)
      8'h57, 8'h52: begin
        for (int k = 3; k >= 0; k--) bytes.push_back(a[8*k +: 8]);
        ra[u] = a;
      end
      default: ;
    endcase
    ea = {ra[u][31:2], 2'b00};
    case (cmd)
      8'h57: begin
        for (int k = 3; k >= 0; k--) bytes.push_back(d[8*k +: 8]);
        ref_mem[{u[0], ea}] = d;
        exp_wr.push_back({ea, d});
        exp_tx.push_back(8'h06);
`ifdef MONITOR_AUTOINC_EN
        ra[u] = ra[u] + 32'd4;
`endif
      end
      8'h52: begin
        rv = ref_rd(u, ea);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(rv[8*k +: 8]);
`ifdef MONITOR_AUTOINC_EN
        ra[u] = ra[u] + 32'd4;
`endif
      end
`ifdef MONITOR_AUTOINC_EN
      8'h77: begin
        for (int k = 3; k >= 0; k--) bytes.push_back(d[8*k +: 8]);
        ref_mem[{u[0], ea}] = d;
        exp_wr.push_back({ea, d});
        exp_tx.push_back(8'h06);
        ra[u] = ra[u] + 32'd4;
      end
      8'h72: begin
        rv = ref_rd(u, ea);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(rv[8*k +: 8]);
        ra[u] = ra[u] + 32'd4;
      end
`endif
      default: exp_tx.push_back(8'h15);
    endcase
    foreach (bytes[i]) begin
      send_byte(u, bytes[i]);
      repeat ($urandom_range(32'(gap))) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int u);
    int n;
    n = 0;
    while ((obs_tx[u].size() < exp_tx.size() || busy[u]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL done_timeout u%0d: got %0d bytes want %0d", u, obs_tx[u].size(), exp_tx.size());
    end
  endtask

  task automatic test_reset();
    logic [75:0] got;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      got = {rx_ready[u], tx_valid[u], tx_data[u], prg_we[u], busy[u], prg_addr[u], prg_wd[u]};
      total++;
      if (got !== {1'b1, 75'd0}) begin
        bad++;
        $display("FAIL reset_state u%0d: got %h want %h", u, got, {1'b1, 75'd0});
      end
    end
    @(negedge clk);
    reset = 1'b0;
    ra[0] = '0;
    ra[1] = '0;
  endtask

  task automatic test_write();
    logic [7:0] seq [9];
    seq = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_q(0);
    rdy_pct[0] = 100;
    foreach (seq[i]) send_byte(0, seq[i]);
    ref_mem[{1'b0, 32'h10}] = 32'hDEADBEEF;
    ra[0] = 32'h10;
`ifdef MONITOR_AUTOINC_EN
    ra[0] = 32'h14;
`endif
    total++;
    if ({prg_we[0], tx_valid[0], prg_addr[0], prg_wd[0]} !== {2'b10, 32'h10, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL write_pulse: got we=%b txv=%b addr=%h wd=%h want we=1 txv=0 addr=00000010 wd=deadbeef",
               prg_we[0], tx_valid[0], prg_addr[0], prg_wd[0]);
    end
    @(posedge clk);
    #1;
    total++;
    if ({prg_we[0], tx_valid[0], tx_data[0]} !== {2'b01, 8'h06}) begin
      bad++;
      $display("FAIL write_ack_timing: got we=%b txv=%b tx=%h want we=0 txv=1 tx=06", prg_we[0], tx_valid[0], tx_data[0]);
    end
    exp_tx.push_back(8'h06);
    wait_done(0);
    total++;
    if (obs_tx[0].size() != 1 || obs_tx[0][0] !== 8'h06) begin
      bad++;
      $display("FAIL write_ack: got %0d bytes first %h want 1 byte 06", obs_tx[0].size(), obs_tx[0].size() ? obs_tx[0][0] : 8'h00);
    end
    total++;
    if (obs_wr[0].size() != 1) begin
      bad++;
      $display("FAIL write_count: got %0d want 1", obs_wr[0].size());
    end
  endtask

  task automatic test_read_latency();
    logic [31:0] want;
    want = 32'hDEADBEEF;
    env_mem[{1'b1, 32'h10}] = 32'hDEADBEEF;
    ref_mem[{1'b1, 32'h10}] = 32'hDEADBEEF;
    for (int u = 0; u < 2; u++) begin
      clear_q(u);
      rdy_pct[u] = 70;
      issue_cmd(u, 8'h52, 32'h10, 32'h0, 0);
      wait_done(u);
      total++;
      if (obs_tx[u].size() != 4) begin
        bad++;
        $display("FAIL read_len u%0d: got %0d want 4", u, obs_tx[u].size());
      end
      for (int k = 0; k < 4 && k < obs_tx[u].size(); k++) begin
        total++;
        if (obs_tx[u][k] !== want[8*(3-k) +: 8]) begin
          bad++;
          $display("FAIL read_byte u%0d #%0d: got %h want %h", u, k, obs_tx[u][k], want[8*(3-k) +: 8]);
        end
      end
      total++;
      if (obs_wr[u].size() != 0) begin
        bad++;
        $display("FAIL read_no_write u%0d: got %0d writes want 0", u, obs_wr[u].size());
      end
    end
  endtask

  task automatic test_nak();
    clear_q(0);
    issue_cmd(0, 8'h41, 32'h0, 32'h0, 1);
    wait_done(0);
    total++;
    if (obs_tx[0].size() != 1 || obs_tx[0][0] !== 8'h15) begin
      bad++;
      $display("FAIL nak_byte: got %0d bytes first %h want 1 byte 15", obs_tx[0].size(), obs_tx[0].size() ? obs_tx[0][0] : 8'h00);
    end
    total++;
    if (obs_wr[0].size() != 0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL nak_idle: got writes=%0d busy=%b want writes=0 busy=0", obs_wr[0].size(), busy[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0;
    int n;
    clear_q(0);
    force_low[0] = 1'b1;
    issue_cmd(0, 8'h52, 32'h10, 32'h0, 2);
    n = 0;
    while (!tx_valid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    d0 = tx_data[0];
    total++;
    if (d0 !== 8'hDE || tx_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL bp_first: got txv=%b tx=%h want txv=1 tx=de", tx_valid[0], d0);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if ({tx_valid[0], tx_data[0]} !== {1'b1, d0}) begin
        bad++;
        $display("FAIL bp_stable c%0d: got txv=%b tx=%h want txv=1 tx=%h", c, tx_valid[0], tx_data[0], d0);
      end
    end
    force_low[0] = 1'b0;
    rdy_pct[0]   = 40;
    wait_done(0);
    total++;
    if (obs_tx[0].size() != exp_tx.size()) begin
      bad++;
      $display("FAIL bp_len: got %0d want %0d", obs_tx[0].size(), exp_tx.size());
    end
    for (int k = 0; k < exp_tx.size() && k < obs_tx[0].size(); k++) begin
      total++;
      if (obs_tx[0][k] !== exp_tx[k]) begin
        bad++;
        $display("FAIL bp_byte #%0d: got %h want %h", k, obs_tx[0][k], exp_tx[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q(0);
    send_byte(0, 8'h57);
    send_byte(0, 8'h00);
    send_byte(0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy[0], tx_valid[0], prg_we[0], rx_ready[0]} !== 4'b0001) begin
      bad++;
      $display("FAIL midreset_state: got busy=%b txv=%b we=%b rxr=%b want 0 0 0 1", busy[0], tx_valid[0], prg_we[0], rx_ready[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    ra[0] = '0;
    ra[1] = '0;
    repeat (3) @(negedge clk);
    total++;
    if (obs_wr[0].size() != 0 || obs_tx[0].size() != 0) begin
      bad++;
      $display("FAIL midreset_quiet: got writes=%0d bytes=%0d want 0 0", obs_wr[0].size(), obs_tx[0].size());
    end
    issue_cmd(0, 8'h57, 32'h20, 32'h1234_5678, 1);
    wait_done(0);
    total++;
    if (obs_wr[0].size() != 1 || obs_wr[0][0] !== {32'h20, 32'h1234_5678}) begin
      bad++;
      $display("FAIL midreset_write: got n=%0d %h want n=1 %h", obs_wr[0].size(), obs_wr[0].size() ? obs_wr[0][0] : 64'h0, {32'h20, 32'h1234_5678});
    end
    total++;
    if (obs_tx[0].size() != 1 || obs_tx[0][0] !== 8'h06) begin
      bad++;
      $display("FAIL midreset_ack: got %0d bytes want 1 byte 06", obs_tx[0].size());
    end
  endtask

  task automatic test_short_cmds();
    logic [63:0] want_wr [$];
    logic [7:0]  want_tx [$];
    clear_q(0);
`ifdef MONITOR_AUTOINC_EN
    issue_cmd(0, 8'h57, 32'hFFFF_FFFC, 32'h0000_0001, 0);
    wait_done(0);
    issue_cmd(0, 8'h77, 32'h0, 32'h0000_0002, 0);
    wait_done(0);
    want_wr = '{{32'hFFFF_FFFC, 32'h1}, {32'h0, 32'h2}};
    want_tx = '{8'h06, 8'h06};
`else
    issue_cmd(0, 8'h77, 32'h0, 32'h0000_0002, 0);
    wait_done(0);
    issue_cmd(0, 8'h72, 32'h0, 32'h0, 0);
    wait_done(0);
    want_tx = '{8'h15, 8'h15};
`endif
    total++;
    if (obs_wr[0].size() != want_wr.size()) begin
      bad++;
      $display("FAIL short_wr_count: got %0d want %0d", obs_wr[0].size(), want_wr.size());
    end
    for (int k = 0; k < want_wr.size() && k < obs_wr[0].size(); k++) begin
      total++;
      if (obs_wr[0][k] !== want_wr[k]) begin
        bad++;
        $display("FAIL short_wr #%0d: got %h want %h", k, obs_wr[0][k], want_wr[k]);
      end
    end
    total++;
    if (obs_tx[0].size() != 2 || obs_tx[0][0] !== want_tx[0] || obs_tx[0][1] !== want_tx[1]) begin
      bad++;
      $display("FAIL short_tx: got n=%0d want n=2 bytes %h %h", obs_tx[0].size(), want_tx[0], want_tx[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [31:0] a, d;
    int          pick;
    for (int u = 0; u < 2; u++) begin
      clear_q(u);
      viol[u] = 0;
      for (int t = 0; t < 40; t++) begin
        rdy_pct[u] = 30 + int'($urandom_range(70));
        pick = int'($urandom_range(9));
        case (pick)
          0, 1, 2: cmd = 8'h57;
          3, 4, 5: cmd = 8'h52;
          6:       cmd = 8'h77;
          7:       cmd = 8'h72;
          default: cmd = 8'($urandom_range(255));
        endcase
        a = ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(31));
        d = $urandom;
        issue_cmd(u, cmd, a, d, 3);
        wait_done(u);
      end
      total++;
      if (obs_tx[u].size() != exp_tx.size() || obs_wr[u].size() != exp_wr.size()) begin
        bad++;
        $display("FAIL rand_len u%0d: got tx=%0d wr=%0d want tx=%0d wr=%0d", u, obs_tx[u].size(), obs_wr[u].size(), exp_tx.size(), exp_wr.size());
      end
      for (int k = 0; k < exp_tx.size() && k < obs_tx[u].size(); k++) begin
        total++;
        if (obs_tx[u][k] !== exp_tx[k]) begin
          bad++;
          $display("FAIL rand_tx u%0d #%0d: got %h want %h", u, k, obs_tx[u][k], exp_tx[k]);
        end
      end
      for (int k = 0; k < exp_wr.size() && k < obs_wr[u].size(); k++) begin
        total++;
        if (obs_wr[u][k] !== exp_wr[k]) begin
          bad++;
          $display("FAIL rand_wr u%0d #%0d: got %h want %h", u, k, obs_wr[u][k], exp_wr[k]);
        end
      end
      total++;
      if (viol[u] != 0) begin
        bad++;
        $display("FAIL rand_protocol u%0d: got %0d violations want 0", u, viol[u]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int u = 0; u < 2; u++) begin
      rx_valid[u]  = 1'b0;
      rx_data[u]   = 8'h00;
      force_low[u] = 1'b0;
      rdy_pct[u]   = 100;
      ra[u]        = '0;
      viol[u]      = 0;
      hold[u]      = 1'b0;
      we_d[u]      = 1'b0;
      prg_rd[u]    = '0;
    end
    reset = 1'b1;
    test_reset();
    test_write();
    test_read_latency();
    test_nak();
    test_backpressure();
    test_reset_mid();
    test_short_cmds();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/monitor_mem_master.md
MONITOR_MEM_MASTER -- requirements
Module: monitor_mem_master

Interface
REQ-001 Parameter RD_LATENCY, default 1, SHALL give the clock cycles from prg_addr valid to prg_rd valid; legal range 1..4.
REQ-002 clk  input  1  SHALL be the single clock for all logic; prg_clk of the attached data memory is driven from the same net externally.
REQ-003 reset  input  1  SHALL be asynchronous, active-high; all state clears on assertion.
REQ-004 rx_data  input  8  command/operand byte from the monitor link.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  block accepts rx_data this cycle.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  link accepts tx_data this cycle.
REQ-010 prg_we  output  1  memory program-port write enable.
REQ-011 prg_addr  output  32  memory program-port byte address; bits [1:0] always 0.
REQ-012 prg_wd  output  32  memory program-port write data.
REQ-013 prg_rd  input  32  memory program-port read data.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 A byte transfers on rx only when rx_valid and rx_ready are both high on a rising clk; likewise on tx with tx_valid and tx_ready.
REQ-016 rx_ready SHALL be high only in IDLE, GET_ADDR and GET_DATA.
REQ-017 tx_data SHALL stay stable while tx_valid is high and tx_ready is low; tx_valid SHALL not drop before the transfer.
REQ-018 States: IDLE, GET_ADDR, GET_DATA, WRITE, READ_WAIT, SEND.
REQ-019 IDLE: 0x57 ('W') -> GET_ADDR (write); 0x52 ('R') -> GET_ADDR (read); any other byte -> SEND with the single byte 0x15 (NAK).
REQ-020 GET_ADDR SHALL accept 4 bytes MSB first into the address register, then go to GET_DATA (write) or READ_WAIT (read).
REQ-021 GET_DATA SHALL accept 4 bytes MSB first into the data register, then go to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with prg_we=1 and prg_addr/prg_wd holding the assembled values, then go to SEND with the single byte 0x06 (ACK).
REQ-023 READ_WAIT SHALL hold prg_addr for RD_LATENCY cycles, capture prg_rd on the last of those cycles, then go to SEND with 4 bytes MSB first.
REQ-024 SEND SHALL return to IDLE on the cycle the last byte transfers.
REQ-025 prg_we SHALL be 0 in every state except WRITE; the address register's bits [1:0] are ignored (prg_addr[1:0]=0).
REQ-026 Gaps of any length between rx bytes SHALL not alter state or assembled values.
REQ-027 Write-to-ACK latency: prg_we pulses on the cycle after the 4th data byte transfers; tx_valid rises the cycle after that.

Reset
REQ-028 On reset: state=IDLE, rx_ready=1, tx_valid=0, tx_data=0x00, prg_we=0, prg_addr=0, prg_wd=0, busy=0, byte counter=0.
REQ-029 Reset mid-command SHALL discard partial operands and any pending response; no prg_we pulse SHALL occur.

Configuration
REQ-030 With macro MONITOR_AUTOINC_EN defined: after every completed WRITE or READ_WAIT the address register increments by 4 (0xFFFFFFFC wraps to 0x00000000); in IDLE, 0x77 ('w') skips GET_ADDR and goes to GET_DATA, and 0x72 ('r') goes directly to READ_WAIT, both using the current address register.
REQ-031 Without MONITOR_AUTOINC_EN: the address register changes only in GET_ADDR, and 0x77/0x72 are treated as unknown commands (NAK).

Verification
REQ-032 Reset, then send 57 00 00 00 10 DE AD BE EF -> one prg_we pulse with prg_addr=0x00000010 and prg_wd=0xDEADBEEF; tx emits 0x06.
REQ-033 Send 52 00 00 00 10, memory model returns 0xDEADBEEF after RD_LATENCY=1 and then again with RD_LATENCY=3 -> tx emits DE AD BE EF in that order.
REQ-034 Send 0x41 -> tx emits 0x15, no prg_we pulse, busy returns to 0 after the transfer.
REQ-035 Hold tx_ready=0 for 10 cycles during a read response -> tx_data/tx_valid stable, no byte lost or duplicated.
REQ-036 Assert reset after 57 00 00 -> busy=0, no prg_we pulse; a following full write command completes normally.
REQ-037 With MONITOR_AUTOINC_EN: send 57 FF FF FF FC 00 00 00 01 then 77 00 00 00 02 -> writes to 0xFFFFFFFC, then to 0x00000000.
